// File: rtl/ncl_sync_adder_port.sv
// ncl_sync_adder_port: clocked boundary port for a dual-rail NCL ripple adder.
// Encodes binary operands into DATA/NULL wavefronts, synchronizes and checks
// the adder's completion and result rails, decodes the sum, returns completion.
// Optional build macro NCL_TIMEOUT_EN adds a per-phase watchdog of TIMEOUT cycles.
module ncl_sync_adder_port #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  output logic [2*WIDTH-1:0] dr_a,
  output logic [2*WIDTH-1:0] dr_b,
  output logic [1:0]         dr_cin,
  input  logic               dr_abcomp,
  input  logic [2*WIDTH-1:0] dr_sum,
  input  logic [1:0]         dr_cout,
  output logic               res_comp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               err
);
  localparam int RW = 2*WIDTH + 2;  // sampled result rails: {cout, sum}

  typedef enum logic [1:0] {IDLE, DATA, NULLW, ERR} state_e;

  typedef struct packed {
    logic [2*WIDTH-1:0] a;
    logic [2*WIDTH-1:0] b;
    logic [1:0]         cin;
  } dr_word_t;

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("ncl_sync_adder_port: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  state_e                         state_q, state_d;
  logic [SYNC_STAGES-1:0]         ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0][RW-1:0] res_sync_q, res_sync_d;
  logic [RW-1:0]                  res_prev_q, res_prev_d;
  dr_word_t                       op_q, op_d, drv_q, drv_d;
  logic                           res_comp_q, res_comp_d;
  logic                           out_valid_q, out_valid_d;
  logic [WIDTH-1:0]               out_sum_q, out_sum_d;
  logic                           out_cout_q, out_cout_d;
  logic                           err_q, err_d;

  logic                           ack_s;
  logic [RW-1:0]                  res_s;
  logic                           res_cmpl, res_null, res_ill, res_stable;
  logic [2*WIDTH-1:0]             enc_a, enc_b;
  logic [1:0]                     enc_cin;
  logic [WIDTH-1:0]               dec_sum;
  logic                           accept, capture;

`ifdef NCL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
  assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`endif

  // per-bit dual-rail encode (1 -> rail1, 0 -> rail0) and rail1 decode
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign enc_a[2*i +: 2] = in_a[i] ? 2'b10 : 2'b01;
    assign enc_b[2*i +: 2] = in_b[i] ? 2'b10 : 2'b01;
    assign dec_sum[i]      = res_s[2*i+1];
  end
  assign enc_cin = in_cin ? 2'b10 : 2'b01;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign res_s = res_sync_q[SYNC_STAGES-1];

  // synchronizer shifts plus completeness / NULL / illegal / stability of res_s
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], dr_abcomp};
    res_sync_d = {res_sync_q[SYNC_STAGES-2:0], dr_cout, dr_sum};
    res_prev_d = res_s;
    res_cmpl   = 1'b1;
    res_ill    = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      res_cmpl = res_cmpl & (res_s[2*i] ^ res_s[2*i+1]);
      res_ill  = res_ill  | (res_s[2*i] & res_s[2*i+1]);
    end
    res_null   = (res_s == '0);
    res_stable = (res_s == res_prev_q);
  end

  assign in_ready = (state_q == IDLE) && !out_valid_q && !ack_s && res_null && res_stable;

  // handshake sequencer: IDLE -> DATA -> NULLW -> IDLE, any rail fault -> ERR
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (res_ill || !res_null) state_d = ERR;
        else if (in_valid && in_ready) begin
          accept  = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (res_ill) state_d = ERR;
        else if (ack_s && res_cmpl && res_stable) begin
          capture = 1'b1;
          state_d = NULLW;
        end
`ifdef NCL_TIMEOUT_EN
        else if (tmo) state_d = ERR;
`endif
      end
      NULLW: begin
        if (res_ill) state_d = ERR;
        else if (!ack_s && res_null && res_stable) state_d = IDLE;
`ifdef NCL_TIMEOUT_EN
        else if (tmo) state_d = ERR;
`endif
      end
      default: state_d = ERR;
    endcase
  end

  // operand hold, wavefront drive, result capture and sticky error
  always_comb begin
    op_d        = accept ? {enc_a, enc_b, enc_cin} : op_q;
    // DATA goes out one cycle after acceptance and drops with the phase exit
    drv_d       = (state_q == DATA && state_d == DATA) ? op_q : '0;
    res_comp_d  = (state_d == NULLW);
    err_d       = err_q | (state_d == ERR);
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_sum_d   = dec_sum;
      out_cout_d  = res_s[2*WIDTH+1];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef NCL_TIMEOUT_EN
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == DATA || state_q == NULLW) cnt_d = cnt_q + 1'b1;
    else cnt_d = cnt_q;
`endif
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state_q     <= IDLE;
      ack_sync_q  <= '0;
      res_sync_q  <= '0;
      res_prev_q  <= '0;
      op_q        <= '0;
      drv_q       <= '0;
      res_comp_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef NCL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= ack_sync_d;
      res_sync_q  <= res_sync_d;
      res_prev_q  <= res_prev_d;
      op_q        <= op_d;
      drv_q       <= drv_d;
      res_comp_q  <= res_comp_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      err_q       <= err_d;
`ifdef NCL_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign dr_a      = drv_q.a;
  assign dr_b      = drv_q.b;
  assign dr_cin    = drv_q.cin;
  assign res_comp  = res_comp_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ncl_sync_adder_port.sv
// tb_ncl_sync_adder_port: drives the port against a behavioural dual-rail adder
// with programmable delay; expected sums come from plain integer addition.
module tb_ncl_sync_adder_port;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam logic [2*W-1:0] INJ = 2'b11;

  logic           clk = 1'b0;
  logic           init_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0, in_b = '0;
  logic           in_cin = 1'b0;
  logic [2*W-1:0] dr_a, dr_b;
  logic [1:0]     dr_cin;
  logic           dr_abcomp = 1'b0;
  logic [2*W-1:0] dr_sum = '0;
  logic [1:0]     dr_cout = '0;
  logic           res_comp, out_valid, out_cout, err;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_sum;

  int n_tests = 0;
  int n_fail  = 0;

  // adder model controls
  int             adder_delay = 7;
  logic           stuck = 1'b0;
  logic           inject = 1'b0;
  logic [2*W+2:0] a_pend = '0, a_out = '0;
  int             a_cnt = 0;

  always #5 clk = ~clk;

  ncl_sync_adder_port #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(16)) dut (
    .clk(clk), .init_n(init_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dr_a(dr_a), .dr_b(dr_b), .dr_cin(dr_cin),
    .dr_abcomp(dr_abcomp), .dr_sum(dr_sum), .dr_cout(dr_cout),
    .res_comp(res_comp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .err(err)
  );

  // dual-rail adder: outputs settle adder_delay cycles after inputs stop changing
  always @(negedge clk) begin : adder_model
    logic [2*W+2:0] tgt;
    logic [W-1:0]   va, vb;
    logic [W:0]     s;
    logic           ok;
    tgt = a_pend;
    va = '0; vb = '0; s = '0; ok = 1'b1;
    if (stuck || ({dr_a, dr_b, dr_cin} == '0)) tgt = '0;
    else begin
      for (int i = 0; i < W; i++) begin
        ok = ok & (dr_a[2*i] ^ dr_a[2*i+1]) & (dr_b[2*i] ^ dr_b[2*i+1]);
        va[i] = dr_a[2*i+1];
        vb[i] = dr_b[2*i+1];
      end
      ok = ok & (dr_cin[0] ^ dr_cin[1]);
      if (ok) begin
        s = va + vb + dr_cin[1];
        tgt = '0;
        tgt[2*W+2] = 1'b1;
        tgt[2*W +: 2] = s[W] ? 2'b10 : 2'b01;
        for (int i = 0; i < W; i++) tgt[2*i +: 2] = s[i] ? 2'b10 : 2'b01;
      end
    end
    if (tgt != a_pend) begin
      a_pend = tgt;
      a_cnt  = 1;
    end else if (a_cnt < 1000) a_cnt++;
    if (a_cnt >= adder_delay) a_out = a_pend;
    dr_abcomp = a_out[2*W+2];
    dr_cout   = a_out[2*W +: 2];
    dr_sum    = a_out[2*W-1:0] | (inject ? INJ : '0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    init_n = 1'b0;
    tick();
    tick();
    init_n = 1'b1;
  endtask

  // wait for in_ready, present operands for exactly the accepting edge
  task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    while (!in_ready && n < 400) begin tick(); n++; end
    chk("in_ready_wait", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
  endtask

  // wait for the result, hold off out_ready for 'hold' cycles, then consume
  task automatic finish_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input int hold);
    logic [W:0] e;
    int n = 0;
    e = a + b + cin;
    while (!out_valid && n < 500) begin tick(); n++; end
    chk("out_valid_wait", out_valid, 1);
    chk("sum", out_sum, e[W-1:0]);
    chk("cout", out_cout, e[W]);
    chk("res_comp_hi", res_comp, 1);
    chk("dr_null_after", {dr_a, dr_b, dr_cin} == '0, 1);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", {out_cout, out_sum}, e);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_clr", out_valid, 0);
    n = 0;
    while (res_comp && n < 500) begin tick(); n++; end
    chk("res_comp_lo", res_comp, 0);
    chk("err_clean", err, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rc;
    // reset state
    init_n = 1'b0;
    tick(); tick();
    chk("rst_dr", {dr_a, dr_b, dr_cin}, 0);
    chk("rst_res_comp", res_comp, 0);
    chk("rst_out", {out_valid, out_cout, out_sum}, 0);
    chk("rst_err", err, 0);
    init_n = 1'b1;
    tick(); tick();
    chk("idle_ready", in_ready, 1);

    // latency with a near-zero-delay adder
    adder_delay = 1;
    start_add(4'h6, 4'h2, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("latency", n, 1 + SS + 2);
    finish_add(4'h6, 4'h2, 1'b0, 0);

    // basic add, 7-cycle adder
    adder_delay = 7;
    start_add(4'h5, 4'h3, 1'b0);
    n = 0;
    while ({dr_a, dr_b, dr_cin} == '0 && n < 10) begin tick(); n++; end
    chk("dr_data_lat", n, 1);
    finish_add(4'h5, 4'h3, 1'b0, 0);

    // carry out, then back-to-back zero add
    start_add(4'hF, 4'h1, 1'b1);
    finish_add(4'hF, 4'h1, 1'b1, 0);
    start_add(4'h0, 4'h0, 1'b0);
    finish_add(4'h0, 4'h0, 1'b0, 0);

    // backpressure
    start_add(4'h6, 4'h7, 1'b1);
    finish_add(4'h6, 4'h7, 1'b1, 20);
    start_add(4'hA, 4'h5, 1'b0);
    finish_add(4'hA, 4'h5, 1'b0, 0);

    // randomized operands, adder delays and consumer stalls
    for (int t = 0; t < 16; t++) begin
      adder_delay = $urandom_range(1, 9);
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      start_add(ra, rb, rc);
      finish_add(ra, rb, rc, $urandom_range(0, 3));
    end

    // reset mid-operation
    adder_delay = 7;
    start_add(4'h9, 4'h9, 1'b1);
    tick();
    init_n = 1'b0;
    tick();
    chk("midrst_dr", {dr_a, dr_b, dr_cin}, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_err", err, 0);
    init_n = 1'b1;
    start_add(4'h2, 4'h2, 1'b0);
    finish_add(4'h2, 4'h2, 1'b0, 0);

    // adder never acknowledges
    stuck = 1'b1;
    start_add(4'h1, 4'h1, 1'b0);
`ifdef NCL_TIMEOUT_EN
    n = 0;
    while (!err && n < 100) begin tick(); n++; end
    chk("timeout_lat", n, 16);
    chk("timeout_dr", {dr_a, dr_b, dr_cin}, 0);
`else
    repeat (40) tick();
    chk("stall_err", err, 0);
    chk("stall_valid", out_valid, 0);
    chk("stall_dr", {dr_a, dr_b, dr_cin} != '0, 1);
`endif
    do_reset();
    stuck = 1'b0;
    repeat (12) tick();

    // illegal rail during DATA
    adder_delay = 7;
    start_add(4'h3, 4'h4, 1'b0);
    tick();
    inject = 1'b1;
    n = 0;
    while (!err && n < 20) begin tick(); n++; end
    chk("ill_err", err, 1);
    chk("ill_lat", n <= SS + 1, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ill_dr", {dr_a, dr_b, dr_cin}, 0);
      chk("ill_res_comp", res_comp, 0);
      chk("ill_ready", in_ready, 0);
    end
    inject = 1'b0;
    repeat (10) tick();
    chk("ill_sticky", err, 1);
    do_reset();
    chk("ill_rst_err", err, 0);
    repeat (10) tick();
    start_add(4'hC, 4'h7, 1'b1);
    finish_add(4'hC, 4'h7, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ncl_sync_adder_port.md
Name: ncl_sync_adder_port

Overview:
- Clocked boundary port that drives a dual-rail NCL ripple-adder chain and collects its result.
- Transmit side: binary operands are encoded to dual-rail and sequenced as DATA/NULL wavefronts, paced by the adder's input completion signal.
- Receive side: the dual-rail sum/carry is sampled, checked for completeness, decoded to binary, and completion is returned to the adder.
- Sits between synchronous logic and the NCL adder datapath, closing both ends of the handshake.

Parameters:
- WIDTH, 4, operand/sum bit count.
- SYNC_STAGES, 2, synchronizer flops on every asynchronous input (min 2).
- TIMEOUT, 255, max cycles in DATA or NULLW before error (used only with the optional feature).

Ports:
- clk  in  1  clock.
- init_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  port accepts operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry in.
- dr_a  out  2*WIDTH  dual-rail A; bit i rail0 = [2i], rail1 = [2i+1].
- dr_b  out  2*WIDTH  dual-rail B, same packing.
- dr_cin  out  2  dual-rail carry in.
- dr_abcomp  in  1  adder input completion; 1 = inputs hold DATA (request NULL), 0 = request DATA.
- dr_sum  in  2*WIDTH  dual-rail sum from the adder.
- dr_cout  in  2  dual-rail carry out.
- res_comp  out  1  completion returned to the adder's sum/carry stage; 0 = request DATA, 1 = request NULL.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  result consumer ready.
- out_sum  out  WIDTH  decoded sum.
- out_cout  out  1  decoded carry out.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (init_n=0 at a clk edge):
  - state=IDLE.
  - dr_a, dr_b, dr_cin all 0 (NULL).
  - res_comp=0; out_valid=0; out_sum=0; out_cout=0; err=0.
  - Synchronizers cleared.
  - Reset mid-transfer drops in-flight data; outputs are NULL on the next cycle.
- Input conditioning:
  - dr_abcomp, dr_sum and dr_cout each pass through SYNC_STAGES flops; the sampled values are called ack_s and res_s.
  - res_s is "complete" when every pair is 01 or 10; "null" when all rails are 0; "illegal" when any pair is 11.
  - complete/null must be identical for 2 consecutive sampled cycles before acting (stability filter).
- in_ready = (state==IDLE) && !out_valid && ack_s==0 && res_s null-stable.
- States:
  - IDLE:
    - Drive NULL.
    - On in_valid && in_ready: register the encoded operands (bit=1 -> rail1 high, bit=0 -> rail0 high), go to DATA.
    - DATA appears on dr_* the cycle after acceptance.
  - DATA:
    - Hold DATA.
    - When ack_s==1 and res_s complete-stable: capture the decoded sum (rail1 of each pair) and cout, set out_valid=1, res_comp=1, go to NULLW.
    - dr_* become NULL on the next cycle.
  - NULLW:
    - Drive NULL; res_comp=1.
    - When ack_s==0 and res_s null-stable: res_comp=0, go to IDLE.
  - ERR:
    - Drive NULL; res_comp=0; err=1.
    - Stay until reset.
- out_valid/out_sum/out_cout hold until out_valid && out_ready; the flag clears on that edge.
- Only one transfer is ever in flight. No new DATA is sent while out_valid=1.
- Illegal res_s in any state, or res_s going non-NULL while in IDLE -> ERR next cycle.
- Boundaries:
  - in_valid with in_ready=0 is ignored; operands must be held by the source.
  - out_ready with out_valid=0: no effect.
  - Data-dependent adder delay is unbounded; the port waits indefinitely unless the optional feature is built in.
- Latency, ideal zero-delay adder: accept edge -> out_valid high after 1 + SYNC_STAGES + 2 cycles.

Optional Feature:
- Macro: NCL_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on each entry to DATA or NULLW.
  - If the counter reaches TIMEOUT before the state's exit condition, go to ERR.
- Undefined:
  - No counter logic.
  - ERR is reached only via illegal/unexpected rails.
  - The TIMEOUT parameter is unused.

Test Plan:
- Basic add: WIDTH=4, a=4'h5, b=4'h3, cin=0, bench adder with 7-cycle delay -> out_sum=4'h8, out_cout=0; dr_* back to NULL; res_comp pulses 1 then 0.
- Carry out and back-to-back: a=4'hF, b=4'h1, cin=1 -> sum=4'h1, cout=1. Then a=0, b=0, cin=0 is accepted only after NULLW -> IDLE; result sum=0, cout=0.
- Backpressure: out_ready=0 for 20 cycles after a result -> out_valid and values hold; in_ready=0; next transfer starts only after the out_ready handshake.
- Illegal rail: adder model drives dr_sum pair 0 = 11 during DATA -> err=1 within SYNC_STAGES+1 cycles; dr_* NULL; in_ready stays 0 until init_n low.
- Reset mid-operation: assert init_n=0 while in DATA -> next cycle dr_*=0, out_valid=0, err=0; a fresh add of 2+2 afterwards gives 4.
- With NCL_TIMEOUT_EN, TIMEOUT=16: adder never raises dr_abcomp -> err=1 exactly 16 cycles after entering DATA. Without the macro, same stimulus -> err stays 0 and the port waits in DATA.
